// File: rtl/wb_stage.sv
// wb_stage: registered, handshaked write-back stage feeding one register-file write port.
// Define WB_MISALIGN_CHECK_EN to add misalign_o and reject misaligned loads at accept.
//
// state    | meaning
// IDLE     | accepting; non-load results retire the following cycle
// WAIT_MEM | load accepted, waiting for mem_rvalid_i
// DRAIN    | load flushed, discarding its pending response
module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_INC     = 4,
  parameter int LSB_W      = $clog2(DATA_WIDTH/8)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  flush_i,
  input  logic [1:0]            result_src_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] csr_rdata_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rd_we_i,
  input  logic [2:0]            load_funct3_i,
  input  logic [LSB_W-1:0]      addr_lsb_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  busy_o
`ifdef WB_MISALIGN_CHECK_EN
  ,
  output logic                  misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_t;

  localparam logic [1:0] SRC_MEM = 2'b01;

  state_t                  state;
  logic [REG_ADDR_W-1:0]   ld_rd;
  logic                    ld_we;
  logic [2:0]              ld_f3;
  logic [LSB_W-1:0]        ld_lsb;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [DATA_WIDTH-1:0]   load_data;

  // Lanes shifted in from above the word read as zero; on a 32-bit datapath LW/LWU/LD collapse to the full word.
  function automatic logic [DATA_WIDTH-1:0] extract(input logic [2:0] f3,
                                                    input logic [LSB_W-1:0] lsb,
                                                    input logic [DATA_WIDTH-1:0] raw);
    logic [DATA_WIDTH-1:0] sh;
    sh = raw >> {lsb, 3'b000};
    case (f3)
      3'b000:  return DATA_WIDTH'($signed(sh[7:0]));
      3'b001:  return DATA_WIDTH'($signed(sh[15:0]));
      3'b010:  return DATA_WIDTH'($signed(sh[31:0]));
      3'b100:  return DATA_WIDTH'(sh[7:0]);
      3'b101:  return DATA_WIDTH'(sh[15:0]);
      3'b110:  return DATA_WIDTH'(sh[31:0]);
      default: return sh;
    endcase
  endfunction

`ifdef WB_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [LSB_W-1:0] lsb);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return lsb[0];
      3'b010, 3'b110: return lsb[1:0] != 2'b00;
      default:        return lsb != '0;
    endcase
  endfunction
`endif

  assign ready_o   = (state == IDLE);
  assign busy_o    = (state != IDLE);
  assign accept    = valid_i & ready_o & ~flush_i;
  assign load_data = extract(ld_f3, ld_lsb, mem_rdata_i);

  always_comb begin
    sel_data = alu_result_i;
    case (result_src_i)
      2'b10:   sel_data = pc_i + DATA_WIDTH'(PC_INC);
      2'b11:   sel_data = csr_rdata_i;
      default: sel_data = alu_result_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      ld_rd      <= '0;
      ld_we      <= 1'b0;
      ld_f3      <= '0;
      ld_lsb     <= '0;
`ifdef WB_MISALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      rf_we_o <= 1'b0;
`ifdef WB_MISALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            if (result_src_i != SRC_MEM) begin
              // Address/data only move on a real write so they hold otherwise.
              if (rd_we_i && (rd_addr_i != '0)) begin
                rf_we_o    <= 1'b1;
                rf_waddr_o <= rd_addr_i;
                rf_wdata_o <= sel_data;
              end
            end else begin
              ld_rd  <= rd_addr_i;
              ld_we  <= rd_we_i;
              ld_f3  <= load_funct3_i;
              ld_lsb <= addr_lsb_i;
`ifdef WB_MISALIGN_CHECK_EN
              if (is_misaligned(load_funct3_i, addr_lsb_i)) misalign_o <= 1'b1;
              else                                          state      <= WAIT_MEM;
`else
              state <= WAIT_MEM;
`endif
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid_i) begin
            if (!flush_i && ld_we && (ld_rd != '0)) begin
              rf_we_o    <= 1'b1;
              rf_waddr_o <= ld_rd;
              rf_wdata_o <= load_data;
            end
            state <= IDLE;
          end else if (flush_i) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_rvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage (default build): directed scenarios plus a randomized mix
// compared against an arithmetic reference of the write-back rules.
module tb_wb_stage;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int LW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          valid_i;
  logic          ready_o;
  logic          flush_i;
  logic [1:0]    result_src_i;
  logic [DW-1:0] alu_result_i;
  logic [DW-1:0] pc_i;
  logic [DW-1:0] csr_rdata_i;
  logic [RW-1:0] rd_addr_i;
  logic          rd_we_i;
  logic [2:0]    load_funct3_i;
  logic [LW-1:0] addr_lsb_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          rf_we_o;
  logic [RW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] last_waddr;
  logic [DW-1:0] last_wdata;

  wb_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(RW), .PC_INC(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .result_src_i(result_src_i), .alu_result_i(alu_result_i), .pc_i(pc_i),
    .csr_rdata_i(csr_rdata_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .load_funct3_i(load_funct3_i), .addr_lsb_i(addr_lsb_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  // Reference: pick the lane by plain division/modulo, sign-extend by adding the upper ones.
  function automatic logic [DW-1:0] ref_load(int f3, int lsb, logic [DW-1:0] raw);
    longint unsigned w;
    longint unsigned v;
    w = 64'(raw) >> (8 * lsb);
    case (f3)
      0: begin v = w % 256;   if (v >= 128)   v = v + 64'hFFFF_FFFF_FFFF_FF00; end
      1: begin v = w % 65536; if (v >= 32768) v = v + 64'hFFFF_FFFF_FFFF_0000; end
      4: v = w % 256;
      5: v = w % 65536;
      default: v = w % (64'd1 << DW);
    endcase
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] ref_sel(int src, logic [DW-1:0] alu, logic [DW-1:0] pc,
                                            logic [DW-1:0] csr);
    longint unsigned link;
    link = (64'(pc) + 64'd4) % (64'd1 << DW);
    if (src == 2) return link[DW-1:0];
    if (src == 3) return csr;
    return alu;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; flush_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    result_src_i = 2'b00; alu_result_i = '0; pc_i = '0; csr_rdata_i = '0;
    rd_addr_i = '0; rd_we_i = 1'b0; load_funct3_i = '0; addr_lsb_i = '0;
  endtask

  task automatic send(int src, logic [DW-1:0] alu, logic [DW-1:0] pc, logic [DW-1:0] csr,
                      int rd, bit we, int f3, int lsb);
    valid_i = 1'b1; result_src_i = 2'(src); alu_result_i = alu; pc_i = pc; csr_rdata_i = csr;
    rd_addr_i = RW'(rd); rd_we_i = we; load_funct3_i = 3'(f3); addr_lsb_i = LW'(lsb);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, ready_o} !== {1'b0, RW'(0), DW'(0), 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset got we=%0b waddr=%0d wdata=%h busy=%0b ready=%0b want 0 0 0 0 1",
               rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, ready_o);
    end
    rst_ni = 1'b1;
    last_waddr = '0; last_wdata = '0;
    tick();
  endtask

  task automatic test_alu();
    send(0, 32'h1234_5678, 0, 0, 5, 1, 0, 0);
    tick(); valid_i = 1'b0;
    checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o, ready_o} !== {1'b1, 5'd5, 32'h1234_5678, 1'b1}) begin
      errors++;
      $display("FAIL alu_rd5 got we=%0b waddr=%0d wdata=%h want 1 5 12345678", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    last_waddr = 5; last_wdata = 32'h1234_5678;
    tick();
    checks++;
    if (rf_we_o !== 1'b0) begin errors++; $display("FAIL alu_pulse got we=%0b want 0", rf_we_o); end
    send(0, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0);
    tick(); valid_i = 1'b0;
    checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b0, last_waddr, last_wdata}) begin
      errors++;
      $display("FAIL alu_x0 got we=%0b waddr=%0d wdata=%h want 0 %0d %h", rf_we_o, rf_waddr_o, rf_wdata_o, last_waddr, last_wdata);
    end
    send(0, 32'hCAFE_0001, 0, 0, 7, 0, 0, 0);
    tick(); valid_i = 1'b0;
    checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b0, last_waddr, last_wdata}) begin
      errors++;
      $display("FAIL alu_nowe got we=%0b waddr=%0d wdata=%h want 0 %0d %h", rf_we_o, rf_waddr_o, rf_wdata_o, last_waddr, last_wdata);
    end
  endtask

  task automatic test_pc_link();
    send(2, 0, 32'hFFFF_FFFC, 0, 1, 1, 0, 0);
    tick(); valid_i = 1'b0;
    checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd1, 32'h0}) begin
      errors++;
      $display("FAIL pc_wrap got we=%0b waddr=%0d wdata=%h want 1 1 00000000", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    send(2, 0, 32'h0000_0100, 0, 2, 1, 0, 0);
    tick(); valid_i = 1'b0;
    checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd2, 32'h104}) begin
      errors++;
      $display("FAIL pc_link got we=%0b waddr=%0d wdata=%h want 1 2 00000104", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    last_waddr = 2; last_wdata = 32'h104;
  endtask

  task automatic test_load_one(int f3, int lsb, logic [DW-1:0] raw, int lat, int rd, bit we);
    logic          exp_we;
    logic [DW-1:0] exp_data;
    send(1, $urandom, $urandom, $urandom, rd, we, f3, lsb);
    tick(); valid_i = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      checks++;
      if ({ready_o, busy_o, rf_we_o} !== 3'b010) begin
        errors++;
        $display("FAIL load_wait[%0d] got ready=%0b busy=%0b we=%0b want 0 1 0", i, ready_o, busy_o, rf_we_o);
      end
      if (i == lat) begin mem_rvalid_i = 1'b1; mem_rdata_i = raw; end
      tick();
    end
    mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
    exp_we = we && (rd != 0);
    exp_data = ref_load(f3, lsb, raw);
    if (exp_we) begin last_waddr = RW'(rd); last_wdata = exp_data; end
    checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o, ready_o} !== {exp_we, last_waddr, last_wdata, 1'b1}) begin
      errors++;
      $display("FAIL load f3=%0d lsb=%0d raw=%h got we=%0b waddr=%0d wdata=%h ready=%0b want %0b %0d %h 1",
               f3, lsb, raw, rf_we_o, rf_waddr_o, rf_wdata_o, ready_o, exp_we, last_waddr, last_wdata);
    end
  endtask

  task automatic test_load();
    test_load_one(0, 2, 32'h0080_0000, 3, 9, 1);
    checks++;
    if (rf_wdata_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_const got %h want ffffff80", rf_wdata_o); end
    test_load_one(4, 2, 32'h0080_0000, 3, 9, 1);
    checks++;
    if (rf_wdata_o !== 32'h0000_0080) begin errors++; $display("FAIL lbu_const got %h want 00000080", rf_wdata_o); end
    test_load_one(1, 2, 32'h8001_0000, 1, 10, 1);
    checks++;
    if (rf_wdata_o !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_const got %h want ffff8001", rf_wdata_o); end
    test_load_one(5, 2, 32'h8001_0000, 2, 11, 1);
    checks++;
    if (rf_wdata_o !== 32'h0000_8001) begin errors++; $display("FAIL lhu_const got %h want 00008001", rf_wdata_o); end
    test_load_one(2, 0, 32'h8765_4321, 1, 0, 1);
    test_load_one(3, 0, 32'h1357_9BDF, 2, 12, 1);
  endtask

  task automatic test_flush();
    // flush one cycle after accept, response two cycles later
    send(1, 0, 0, 0, 13, 1, 2, 0);
    tick(); valid_i = 1'b0; flush_i = 1'b1;
    tick(); flush_i = 1'b0;
    checks++;
    if ({busy_o, ready_o, rf_we_o} !== 3'b100) begin
      errors++; $display("FAIL flush_drain got busy=%0b ready=%0b we=%0b want 1 0 0", busy_o, ready_o, rf_we_o);
    end
    tick(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
    tick(); mem_rvalid_i = 1'b0;
    checks++;
    if ({rf_we_o, busy_o, ready_o, rf_wdata_o} !== {3'b001, last_wdata}) begin
      errors++; $display("FAIL flush_discard got we=%0b busy=%0b ready=%0b wdata=%h want 0 0 1 %h", rf_we_o, busy_o, ready_o, rf_wdata_o, last_wdata);
    end
    send(0, 32'h0BAD_F00D, 0, 0, 3, 1, 0, 0);
    tick(); valid_i = 1'b0;
    checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd3, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL flush_after_alu got we=%0b waddr=%0d wdata=%h want 1 3 0badf00d", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    last_waddr = 3; last_wdata = 32'h0BAD_F00D;
    // flush together with the response
    send(1, 0, 0, 0, 14, 1, 2, 0);
    tick(); valid_i = 1'b0; flush_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    tick(); flush_i = 1'b0; mem_rvalid_i = 1'b0;
    checks++;
    if ({rf_we_o, ready_o, rf_wdata_o} !== {2'b01, last_wdata}) begin
      errors++; $display("FAIL flush_with_rvalid got we=%0b ready=%0b wdata=%h want 0 1 %h", rf_we_o, ready_o, rf_wdata_o, last_wdata);
    end
    // stray response in IDLE is ignored
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    tick(); mem_rvalid_i = 1'b0;
    checks++;
    if ({rf_we_o, ready_o} !== 2'b01) begin
      errors++; $display("FAIL idle_rvalid got we=%0b ready=%0b want 0 1", rf_we_o, ready_o);
    end
    // flush in IDLE blocks acceptance but the registered write still retires
    send(0, 32'hA5A5_0001, 0, 0, 4, 1, 0, 0);
    tick();
    send(0, 32'hA5A5_0002, 0, 0, 6, 1, 0, 0); flush_i = 1'b1;
    checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd4, 32'hA5A5_0001}) begin
      errors++; $display("FAIL idle_flush_retire got we=%0b waddr=%0d wdata=%h want 1 4 a5a50001", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    tick(); valid_i = 1'b0; flush_i = 1'b0;
    checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b0, 5'd4, 32'hA5A5_0001}) begin
      errors++; $display("FAIL idle_flush_block got we=%0b waddr=%0d wdata=%h want 0 4 a5a50001", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    last_waddr = 4; last_wdata = 32'hA5A5_0001;
  endtask

  task automatic test_reset_midload();
    send(1, 0, 0, 0, 15, 1, 2, 0);
    tick(); valid_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({ready_o, busy_o, rf_we_o} !== 3'b100) begin
      errors++; $display("FAIL reset_midload got ready=%0b busy=%0b we=%0b want 1 0 0", ready_o, busy_o, rf_we_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    last_waddr = '0; last_wdata = '0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3333_4444;
    tick(); mem_rvalid_i = 1'b0;
    checks++;
    if ({rf_we_o, ready_o, rf_waddr_o, rf_wdata_o} !== {2'b01, RW'(0), DW'(0)}) begin
      errors++; $display("FAIL late_response got we=%0b ready=%0b waddr=%0d wdata=%h want 0 1 0 0", rf_we_o, ready_o, rf_waddr_o, rf_wdata_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp [3];
    int            srcs [3];
    exp[0] = 32'h0000_1111; exp[1] = 32'h0000_00AA; exp[2] = 32'h0000_3333;
    srcs[0] = 0; srcs[1] = 3; srcs[2] = 0;
    for (int i = 0; i < 3; i++) begin
      send(srcs[i], (i == 0) ? exp[0] : exp[2], 0, 32'hAA, 20 + i, 1, 0, 0);
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %0b want 1", i, ready_o); end
      tick();
      checks++;
      if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, RW'(20 + i), exp[i]}) begin
        errors++; $display("FAIL b2b[%0d] got we=%0b waddr=%0d wdata=%h want 1 %0d %h", i, rf_we_o, rf_waddr_o, rf_wdata_o, 20 + i, exp[i]);
      end
    end
    valid_i = 1'b0;
    last_waddr = 22; last_wdata = exp[2];
  endtask

  task automatic test_random();
    int            src;
    int            rd;
    bit            we;
    logic          exp_we;
    logic [DW-1:0] a, p, c;
    for (int n = 0; n < 300; n++) begin
      src = $urandom_range(0, 3);
      rd = $urandom_range(0, 31);
      we = ($urandom_range(0, 3) != 0);
      if (src == 1) begin
        test_load_one($urandom_range(0, 7), $urandom_range(0, 3), $urandom, $urandom_range(1, 4), rd, we);
      end else begin
        a = $urandom; p = $urandom; c = $urandom;
        send(src, a, p, c, rd, we, $urandom_range(0, 7), $urandom_range(0, 3));
        tick();
        exp_we = we && (rd != 0);
        if (exp_we) begin last_waddr = RW'(rd); last_wdata = ref_sel(src, a, p, c); end
        checks++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o, ready_o} !== {exp_we, last_waddr, last_wdata, 1'b1}) begin
          errors++;
          $display("FAIL rand_nonmem[%0d] src=%0d got we=%0b waddr=%0d wdata=%h want %0b %0d %h",
                   n, src, rf_we_o, rf_waddr_o, rf_wdata_o, exp_we, last_waddr, last_wdata);
        end
        if ($urandom_range(0, 2) == 0) valid_i = 1'b0;
      end
    end
    valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_pc_link();
    test_load();
    test_flush();
    test_back_to_back();
    test_reset_midload();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
